// File: rtl/seg_disp_pkg.sv
// ============================================================================
// Module : seg_disp_pkg
// Brief  : Shared FSM encoding, glyph constants and double-dabble helper
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // One double-dabble iteration per magnitude bit
  localparam int unsigned CONV_ITERS = 6;
  localparam int unsigned ITER_W     = 3;

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module : bcd_to_seg
// Brief  : Combinational BCD to active-low 7-segment glyph {g,f,e,d,c,b,a}
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
  import seg_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/signed_seg_display.sv
// ============================================================================
// Module : signed_seg_display
// Brief  : Signed 6-bit value to 4-digit multiplexed 7-segment display.
//          Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_seg_display
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_W = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [13:0]         shift_q, shift_d;
  logic                sign_q, sign_d;
  logic                disp_sign_q, disp_sign_d;
  logic [3:0]          disp_tens_q, disp_tens_d;
  logic [3:0]          disp_units_q, disp_units_d;
  logic [REFRESH_W-1:0] refresh_q, refresh_d;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [5:0]  mag;
  logic [13:0] adj;
  logic [1:0]  digit_idx;
  logic [3:0]  sel_bcd;
  logic [6:0]  glyph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      iter_q       <= '0;
      shift_q      <= '0;
      sign_q       <= 1'b0;
      disp_sign_q  <= 1'b0;
      disp_tens_q  <= 4'd0;
      disp_units_q <= 4'd0;
      refresh_q    <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      shift_q      <= shift_d;
      sign_q       <= sign_d;
      disp_sign_q  <= disp_sign_d;
      disp_tens_q  <= disp_tens_d;
      disp_units_q <= disp_units_d;
      refresh_q    <= refresh_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  // Conversion FSM: display registers only change in DONE
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    shift_d      = shift_q;
    sign_d       = sign_q;
    disp_sign_d  = disp_sign_q;
    disp_tens_d  = disp_tens_q;
    disp_units_d = disp_units_q;
    mag          = in_data[5] ? (~in_data + 6'd1) : in_data;
    adj          = {dd_adjust(shift_q[13:10]), dd_adjust(shift_q[9:6]), shift_q[5:0]};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[5];
          shift_d = {8'd0, mag};
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        shift_d = {adj[12:0], 1'b0};
        iter_d  = iter_q + 1'b1;
        if (iter_q == ITER_W'(CONV_ITERS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_sign_d  = sign_q;
        disp_tens_d  = shift_q[13:10];
        disp_units_d = shift_q[9:6];
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign digit_idx = refresh_q[REFRESH_W-1 -: 2];
  assign sel_bcd   = (digit_idx == 2'd0) ? disp_units_q : disp_tens_q;

  bcd_to_seg u_bcd_to_seg (
    .bcd (sel_bcd),
    .seg (glyph)
  );

  always_comb begin
    refresh_d = refresh_q + REFRESH_W'(1);
    an_d      = ~(4'b0001 << digit_idx);
    seg_d     = SEG_BLANK;
    case (digit_idx)
      2'd0: seg_d = glyph;
      2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = (disp_tens_q == 4'd0) ? SEG_BLANK : glyph;
`else
        seg_d = glyph;
`endif
      end
      2'd2: seg_d = SEG_BLANK;
      2'd3: seg_d = disp_sign_q ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_signed_seg_display.sv
// ============================================================================
// Module : tb_signed_seg_display
// Brief  : Table-driven scoreboard bench for signed_seg_display (REFRESH_W=4)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_signed_seg_display;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MN = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] T0 = BL;
`else
  localparam logic [6:0] T0 = G0;
`endif

  typedef struct {
    logic [5:0] data;
    logic [6:0] d3;
    logic [6:0] d1;
    logic [6:0] d0;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int   errors;
  int   checks;
  logic [6:0] cap [4];
  vec_t vecs [8];
  vec_t exp_q [$];

  signed_seg_display #(.REFRESH_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample one full refresh period and record the glyph seen on each anode
  task automatic capture();
    logic [3:0] seen;
    int bad;
    seen = 4'h0;
    bad  = 0;
    for (int i = 0; i < 40 && seen != 4'hF; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin cap[0] = seg; seen[0] = 1'b1; end
        4'b1101: begin cap[1] = seg; seen[1] = 1'b1; end
        4'b1011: begin cap[2] = seg; seen[2] = 1'b1; end
        4'b0111: begin cap[3] = seg; seen[3] = 1'b1; end
        default: bad++;
      endcase
    end
    check("all_digits_seen", 32'(seen), 32'hF);
    check("an_onehot", 32'(bad), 32'd0);
  endtask

  task automatic compare_display(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      capture();
      check({tag, "_digit3"}, 32'(cap[3]), 32'(e.d3));
      check({tag, "_digit2"}, 32'(cap[2]), 32'(BL));
      check({tag, "_digit1"}, 32'(cap[1]), 32'(e.d1));
      check({tag, "_digit0"}, 32'(cap[0]), 32'(e.d0));
    end
  endtask

  // Offer a value; with noise, keep in_valid high with another value during CONV
  task automatic send(input logic [5:0] d, input bit noise);
    int waits;
    int lows;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_data  = 6'b010001;
    lows = 0;
    while (!in_ready && lows < 20) begin
      in_valid = noise && (lows < 6);
      @(negedge clk);
      lows++;
    end
    in_valid = 1'b0;
    check("ready_low_cycles", 32'(lows), 32'd7);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 6'd0;

    vecs[0] = '{6'b010101, BL, G2, G1};  // +21
    vecs[1] = '{6'b111000, MN, T0, G8};  // -8
    vecs[2] = '{6'b100000, MN, G3, G2};  // -32
    vecs[3] = '{6'b000000, BL, T0, G0};  // +0
    vecs[4] = '{6'b111111, MN, T0, G1};  // -1
    vecs[5] = '{6'b001010, BL, G1, G0};  // +10
    vecs[6] = '{6'b101101, MN, G1, G9};  // -19
    vecs[7] = '{6'b011001, BL, G2, G0};  // +25 (wrong on purpose? no: 25 -> 2,5)
    vecs[7].d0 = 7'b0010010;

    repeat (5) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(BL));
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    exp_q.push_back('{6'd0, BL, T0, G0});
    repeat (2) @(negedge clk);
    compare_display("reset");

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, 1'b0);
      exp_q.push_back(vecs[i]);
      repeat (2) @(negedge clk);
      compare_display($sformatf("vec%0d", i));
    end

    // Value offered during conversion must be dropped
    send(6'b011111, 1'b1);
    exp_q.push_back('{6'b011111, BL, G3, G1});
    repeat (2) @(negedge clk);
    check("ignore_ready", 32'(in_ready), 32'd1);
    compare_display("ignore");

    // Reset mid-conversion aborts without commit
    in_valid = 1'b1;
    in_data  = 6'b011101;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_an", 32'(an), 32'hF);
    check("abort_seg", 32'(seg), 32'(BL));
    check("abort_dp", 32'(dp), 32'd1);
    check("abort_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{6'd0, BL, T0, G0});
    repeat (12) @(negedge clk);
    check("abort_ready_after", 32'(in_ready), 32'd1);
    compare_display("abort");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
